// File: rtl/prdec_seq.sv
// prdec_seq: 2-to-4 one-hot decoder sequencer.
// Accepted codes are queued in a 2-entry FIFO. Each code then drives its
// decoded line for HOLD cycles, followed by two all-zero cycles (GAP + IDLE).
// Code mapping {A,B}: 11->D0, 10->D1, 01->D2, 00->D3.
module prdec_seq #(
  parameter int HOLD = 4  // cycles each decoded line is held, legal 1..15
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic A,
  input  logic B,
  output logic in_ready,
  output logic D0,
  output logic D1,
  output logic D2,
  output logic D3,
  output logic busy,
  output logic done
);

  // Value loaded into the hold counter when a code starts driving.
  // The line stays high until the counter has reached zero, giving HOLD cycles.
  localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  d_q, d_d;          // one-hot decoded lines, bit i -> Di
  logic [3:0]  hold_q, hold_d;    // remaining DRIVE cycles after this one
  logic [1:0]  count_q, count_d;  // FIFO occupancy, 0..2
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  mem_q [2];         // FIFO storage, {A,B} per entry

  logic        push;
  logic        pop;
  logic [1:0]  head_code;
  logic [3:0]  head_onehot;

  // Ready depends only on the registered count, so a pop never frees a slot
  // within the same cycle; the slot shows up as ready one cycle later.
  assign in_ready  = (count_q < 2'd2);
  assign push      = in_valid & in_ready;
  // Popping happens only from IDLE, and only from entries already stored
  // before this edge; a code pushed this cycle is never bypassed to D.
  assign pop       = (state_q == IDLE) && (count_q != 2'd0);
  assign head_code = mem_q[rd_ptr_q];

  // Decode the FIFO head into the one-hot line pattern.
  always_comb begin
    head_onehot = 4'b0000;
    case (head_code)
      2'b11:   head_onehot = 4'b0001;
      2'b10:   head_onehot = 4'b0010;
      2'b01:   head_onehot = 4'b0100;
      default: head_onehot = 4'b1000;
    endcase
  end

  // FIFO pointer and occupancy next-state; 1-bit pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Sequencer next-state: IDLE pops and loads, DRIVE holds, GAP blanks one cycle.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        d_d = 4'b0000;
        if (pop) begin
          d_d     = head_onehot;
          hold_d  = HOLD_LOAD;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (hold_q == 4'd0) begin
          d_d     = 4'b0000;
          state_d = GAP;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      GAP: begin
        d_d     = 4'b0000;
        state_d = IDLE;
      end
      default: begin
        d_d     = 4'b0000;
        hold_d  = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage write; reset clears entries so buffered codes are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= 2'b00;
      mem_q[1] <= 2'b00;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {A, B};
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sequencer state, hold counter and registered output lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= 4'b0000;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      hold_q  <= hold_d;
    end
  end

  assign D0   = d_q[0];
  assign D1   = d_q[1];
  assign D2   = d_q[2];
  assign D3   = d_q[3];
  assign busy = |d_q;
  // Last cycle of a code: still in DRIVE with nothing left on the counter.
  assign done = (state_q == DRIVE) && (hold_q == 4'd0);

endmodule

// File: doc/prdec_seq.md
PRDEC_SEQ -- requirements
Module: prdec_seq

Interface
REQ-001 SHALL have parameter: HOLD, default 4, number of cycles each decoded one-hot line is held (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  encoded code present (the encoder's Y).
REQ-005 SHALL have port: A  input  1  code bit A (the encoder's A).
REQ-006 SHALL have port: B  input  1  code bit B (the encoder's B).
REQ-007 SHALL have port: in_ready  output  1  block can accept a code this cycle.
REQ-008 SHALL have ports: D0, D1, D2, D3  output  1 each  registered one-hot decoded lines.
REQ-009 SHALL have port: busy  output  1  high while any D line is asserted.
REQ-010 SHALL have port: done  output  1  one-cycle pulse on the last HOLD cycle of each code.

Function
REQ-011 SHALL decode {A,B}: 11->D0, 10->D1, 01->D2, 00->D3 (inverse of the team's 4-to-2 priority encoder).
REQ-012 SHALL buffer accepted codes in a 2-entry FIFO; in_ready = (count < 2), driven from registered count only.
REQ-013 SHALL push {A,B} on a rising edge when in_valid && in_ready; in_valid while in_ready low is ignored, no state change.
REQ-014 SHALL implement FSM states IDLE, DRIVE, GAP.
REQ-015 IDLE: if count > 0, SHALL pop the head at the edge, load the one-hot D registers, load hold counter with HOLD-1, go to DRIVE; else stay IDLE with D = 0000.
REQ-016 DRIVE: SHALL hold D constant; decrement counter each edge; when counter = 0, the next edge SHALL clear D to 0000 and go to GAP.
REQ-017 GAP: SHALL keep D = 0000 for exactly one cycle, then go to IDLE.
REQ-018 Consequence: each code SHALL drive its line for exactly HOLD cycles, and consecutive codes SHALL be separated by exactly 2 zero cycles (GAP + IDLE).
REQ-019 Latency: a code pushed into an empty FIFO at edge k while IDLE SHALL drive D from edge k+1.
REQ-020 No FIFO bypass: a push and pop in the same cycle with count=1 SHALL leave count=1 and preserve order.
REQ-021 Pop when full SHALL raise in_ready in the following cycle, never the same cycle.
REQ-022 busy SHALL equal OR of D0..D3; at most one D line SHALL be high at any time.
REQ-023 done SHALL be high exactly in the DRIVE cycle where counter = 0; for HOLD=1 that is the only DRIVE cycle.
REQ-024 FIFO pointers SHALL be 1 bit and wrap 1->0; count SHALL be 2 bits, range 0..2.

Reset
REQ-025 On rst=1, asynchronously and without waiting for clk: D0..D3=0, busy=0, done=0, FSM=IDLE, count=0, pointers=0, hold counter=0; in_ready=1 after reset deasserts.
REQ-026 rst asserted mid-DRIVE SHALL abort the current code and discard buffered codes; no done pulse is produced for the aborted code.
REQ-027 First push SHALL be accepted on the first rising edge with rst=0.

Verification
REQ-028 Single code: HOLD=4, push {A,B}=10 at edge 1 -> D1=1 during cycles 2-5, done=1 in cycle 5, D=0000 in cycles 6-7, in_ready=1 throughout.
REQ-029 All codes: push 11,10,01,00 back-to-back with in_valid held -> D0,D1,D2,D3 each for 4 cycles in that order, 2 zero cycles between, in_ready low while count=2, no code lost or reordered.
REQ-030 Full FIFO: stop popping by keeping DRIVE busy, push 3 codes -> third is held off (in_ready=0) until the cycle after the next pop, then accepted.
REQ-031 HOLD=1: push 01 -> D2 high exactly 1 cycle with done high in that same cycle.
REQ-032 Reset mid-operation: assert rst asynchronously in DRIVE cycle 2 with 1 code buffered -> D=0000 immediately, no further output after release, in_ready=1.
REQ-033 Invariant checks every cycle: one-hot-or-zero D, busy == |D, count <= 2.
